// File: rtl/dsp_sequencer.sv
// DSP instruction sequencer: owns the PC, fetches words over req/ack and issues them to the decoder.
// Optional RPTK single-instruction repeat is built only when DSP_RPT_EN is defined.
module dsp_sequencer #(
    parameter int                    PC_WIDTH     = 12,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [15:0]         imem_rdata,
    output logic [15:0]         instr,
    output logic                instr_valid,
    input  logic                ex_busy,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                wake,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_ISSUE = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam logic [15:0] IDLE_WORD = 16'hCE1F;
    localparam logic [7:0]  RPTK_OP   = 8'hCB;
    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state_r, state_nxt_s;
    logic [PC_WIDTH-1:0] pc_r, pc_nxt_s;
    logic [15:0]         instr_r, instr_nxt_s;

`ifdef DSP_RPT_EN
    // rpt_pend_r marks that the next latched word becomes the repeated one.
    logic [7:0] rpt_cnt_r, rpt_cnt_nxt_s;
    logic       rpt_active_r, rpt_active_nxt_s;
    logic       rpt_pend_r, rpt_pend_nxt_s;
`endif

    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign instr       = instr_r;
    assign imem_req    = (state_r == ST_FETCH) && rst_n;
    assign instr_valid = (state_r == ST_ISSUE);
    assign halted      = (state_r == ST_HALT);

    // Next-state and next-register computation for fetch, issue and halt.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        instr_nxt_s = instr_r;
`ifdef DSP_RPT_EN
        rpt_cnt_nxt_s    = rpt_cnt_r;
        rpt_active_nxt_s = rpt_active_r;
        rpt_pend_nxt_s   = rpt_pend_r;
`endif
        case (state_r)
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_nxt_s = imem_rdata;
                    state_nxt_s = ST_ISSUE;
`ifdef DSP_RPT_EN
                    rpt_active_nxt_s = rpt_pend_r;
                    rpt_pend_nxt_s   = 1'b0;
`endif
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (!ex_busy) begin
                    if (branch_taken) begin
                        pc_nxt_s    = branch_target;
                        state_nxt_s = ST_FETCH;
`ifdef DSP_RPT_EN
                        rpt_cnt_nxt_s    = 8'd0;
                        rpt_active_nxt_s = 1'b0;
                        rpt_pend_nxt_s   = 1'b0;
`endif
                    end
`ifdef DSP_RPT_EN
                    // A repeated RPTK is not itself repeated; it falls through and reloads.
                    else if (rpt_active_r && (rpt_cnt_r != 8'd0) && (instr_r[15:8] != RPTK_OP)) begin
                        rpt_cnt_nxt_s = rpt_cnt_r - 8'd1;
                        state_nxt_s   = ST_ISSUE;
                    end
`endif
                    else if (instr_r == IDLE_WORD) begin
                        pc_nxt_s    = pc_r + PC_ONE;
                        state_nxt_s = ST_HALT;
                    end
`ifdef DSP_RPT_EN
                    else if (instr_r[15:8] == RPTK_OP) begin
                        rpt_cnt_nxt_s  = instr_r[7:0];
                        rpt_pend_nxt_s = 1'b1;
                        pc_nxt_s       = pc_r + PC_ONE;
                        state_nxt_s    = ST_FETCH;
                    end
`endif
                    else begin
                        pc_nxt_s    = pc_r + PC_ONE;
                        state_nxt_s = ST_FETCH;
`ifdef DSP_RPT_EN
                        rpt_active_nxt_s = 1'b0;
`endif
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_HALT: begin
                if (wake) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_VECTOR;
            instr_r <= 16'h0000;
`ifdef DSP_RPT_EN
            rpt_cnt_r    <= 8'd0;
            rpt_active_r <= 1'b0;
            rpt_pend_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            instr_r <= instr_nxt_s;
`ifdef DSP_RPT_EN
            rpt_cnt_r    <= rpt_cnt_nxt_s;
            rpt_active_r <= rpt_active_nxt_s;
            rpt_pend_r   <= rpt_pend_nxt_s;
`endif
        end
    end

endmodule
